bcd_display_scan_ctrl: RTL and testbench

//   Captures a signed product (14-bit magnitude + sign) through a valid/ready handshake.

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/bin_to_bcd.sv | 17 +
 rtl/bcd_display_scan_ctrl.sv | 101 ++++++++++
 tb/tb_bcd_display_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, state encoding and frame formatter for the BCD scanning display.
// The formatter turns five BCD digits plus a sign into six display positions.
package disp_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam int         N_POS     = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CONV  = 2'd1,
        SHOW  = 2'd2
    } disp_state_t;

    typedef logic [N_POS-1:0][3:0] frame_t;

    localparam frame_t FRAME_BLANK = {N_POS{DIG_BLANK}};

    // Leading zeros above d0 are blanked; the minus sign floats into the
    // first blank slot above the most significant shown digit.
    function automatic frame_t format_frame(input logic [19:0] bcd, input logic neg);
        frame_t f;
        logic   nz;
        logic   placed;
        f    = FRAME_BLANK;
        f[0] = bcd[3:0];
        nz   = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            nz = nz | (bcd[4*k +: 4] != 4'd0);
            if (nz) f[k] = bcd[4*k +: 4];
        end
        nz     = nz | (bcd[3:0] != 4'd0);
        placed = 1'b0;
        if (neg && nz) begin
            for (int k = 1; k < N_POS; k++) begin
                if (!placed && f[k] == DIG_BLANK) begin
                    f[k]   = DIG_MINUS;
                    placed = 1'b1;
                end
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational 14-bit binary to 5-digit BCD converter (shift-and-add-3).
module bin_to_bcd (
    input  logic [13:0] in,
    output logic [19:0] bcd
);

    always_comb begin
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int k = 0; k < 5; k++) begin
                if (bcd[4*k +: 4] >= 4'd5) bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
            bcd = {bcd[18:0], in[i]};
        end
    end

endmodule

// File: rtl/bcd_display_scan_ctrl.sv
// Captures a signed value, formats it as a 6-position frame and scans a
// scrollable 4-digit window onto a common-anode digit bank.
module bcd_display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int N_AN        = 4,
    parameter int MAX_OFFSET  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [13:0] value_mag,
    input  logic        value_neg,
    input  logic        scroll_left,
    input  logic        scroll_right,
    output logic [3:0]  an,
    output logic [3:0]  digit_code,
    output logic [1:0]  offset,
    output disp_state_t state_dbg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    disp_state_t        state_q, state_d;
    logic [13:0]        mag_q;
    logic               neg_q;
    frame_t             frame_q;
    logic [1:0]         offset_q, offset_d;
    logic [1:0]         scan_idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         an_q;
    logic [3:0]         digit_q;
    logic [19:0]        bcd;
    logic               accept;
    logic               cnt_wrap;
    logic [2:0]         pos;

    bin_to_bcd u_bin_to_bcd (
        .in  (mag_q),
        .bcd (bcd)
    );

    // Handshake: a value transfers on a cycle where load_valid and
    // load_ready are both high; ready is low only while converting.
    always_comb begin
        load_ready = (state_q != CONV);
        accept     = load_valid && load_ready;
        state_d    = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = CONV;
            CONV:    state_d = SHOW;
            SHOW:    if (accept) state_d = CONV;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        offset_d = offset_q;
        if (scroll_left && !scroll_right && offset_q < 2'(MAX_OFFSET))
            offset_d = offset_q + 2'd1;
        else if (scroll_right && !scroll_left && offset_q != 2'd0)
            offset_d = offset_q - 2'd1;
    end

    assign cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign pos      = {1'b0, offset_q} + {1'b0, scan_idx_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            frame_q    <= FRAME_BLANK;
            offset_q   <= '0;
            scan_idx_q <= '0;
            cnt_q      <= '0;
            an_q       <= 4'b1111;
            digit_q    <= DIG_BLANK;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            if (accept) begin
                mag_q <= value_mag;
                neg_q <= value_neg;
            end
            if (state_q == CONV) frame_q <= format_frame(bcd, neg_q);
            cnt_q <= cnt_wrap ? '0 : cnt_q + CNT_W'(1);
            if (cnt_wrap) scan_idx_q <= scan_idx_q + 2'd1;
            an_q    <= ~(4'b0001 << scan_idx_q);
            digit_q <= frame_q[pos];
        end
    end

    assign an         = an_q;
    assign digit_code = digit_q;
    assign offset     = offset_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Directed bench: loads values, scrolls the window and checks each scanned digit
// against a queue of digits predicted from the loaded value.
module tb_bcd_display_scan_ctrl;
    import disp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [13:0] value_mag;
    logic        value_neg;
    logic        scroll_left;
    logic        scroll_right;
    logic [3:0]  an;
    logic [3:0]  digit_code;
    logic [1:0]  offset;
    disp_state_t state_dbg;

    int          total = 0;
    int          bad   = 0;
    int          exp_off = 0;
    logic [3:0]  exp_q[$];

    bcd_display_scan_ctrl #(.REFRESH_DIV(4), .N_AN(4), .MAX_OFFSET(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .value_mag    (value_mag),
        .value_neg    (value_neg),
        .scroll_left  (scroll_left),
        .scroll_right (scroll_right),
        .an           (an),
        .digit_code   (digit_code),
        .offset       (offset),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference digit for frame position p of a signed value.
    function automatic logic [3:0] exp_digit(input int mag, input bit neg, input int p);
        int d[5];
        int m;
        int nd;
        m  = mag;
        nd = 1;
        for (int k = 0; k < 5; k++) begin
            d[k] = m % 10;
            m    = m / 10;
        end
        for (int k = 1; k < 5; k++) if (d[k] != 0 || (mag / (10 ** k)) != 0) nd = k + 1;
        if (p < nd) return 4'(d[p]);
        if (p == nd && neg && mag != 0) return 4'hA;
        return 4'hF;
    endfunction

    task automatic push_window(input int mag, input bit neg);
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_digit(mag, neg, exp_off + j));
    endtask

    task automatic push_blank();
        for (int j = 0; j < 4; j++) exp_q.push_back(4'hF);
    endtask

    // Wait for each anode in turn and compare its digit with the queue head.
    task automatic check_window(input string tag);
        logic [3:0] want_an;
        logic [3:0] exp_d;
        int         n;
        for (int j = 0; j < 4; j++) begin
            want_an = ~(4'b0001 << j);
            n = 0;
            while (an !== want_an && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (n >= 64) chk({tag, "_an_timeout"}, 32'(an), 32'(want_an));
            exp_d = exp_q.pop_front();
            chk($sformatf("%s_dig%0d", tag, j), 32'(digit_code), 32'(exp_d));
        end
    endtask

    task automatic do_load(input int mag, input bit neg);
        load_valid = 1'b1;
        value_mag  = 14'(mag);
        value_neg  = neg;
        @(negedge clk);
        chk("ready_low", 32'(load_ready), 32'd0);
        chk("state_conv", 32'(state_dbg), 32'(CONV));
        load_valid = 1'b0;
        @(negedge clk);
        chk("ready_back", 32'(load_ready), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic scroll(input bit l, input bit r);
        scroll_left  = l;
        scroll_right = r;
        if (l && !r && exp_off < 2) exp_off++;
        else if (r && !l && exp_off > 0) exp_off--;
        @(negedge clk);
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
        chk("offset", 32'(offset), 32'(exp_off));
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_valid   = 1'b0;
        value_mag    = '0;
        value_neg    = 1'b0;
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_digit", 32'(digit_code), 32'hF);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(EMPTY));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_an0", 32'(an), 32'hE);
        push_blank();
        check_window("idle");

        do_load(1234, 1'b0);
        push_window(1234, 1'b0);
        check_window("pos1234");

        do_load(12345, 1'b1);
        push_window(12345, 1'b1);
        check_window("neg12345_off0");
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        push_window(12345, 1'b1);
        check_window("neg12345_off2");
        scroll(1'b1, 1'b0);
        push_window(12345, 1'b1);
        check_window("neg12345_sat");

        scroll(1'b0, 1'b1);
        scroll(1'b0, 1'b1);
        scroll(1'b0, 1'b1);
        do_load(7, 1'b1);
        push_window(7, 1'b1);
        check_window("neg7");
        do_load(0, 1'b1);
        push_window(0, 1'b1);
        check_window("negzero");

        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b1);
        push_window(0, 1'b1);
        check_window("both_scroll");

        load_valid = 1'b1;
        value_mag  = 14'd5678;
        value_neg  = 1'b0;
        @(negedge clk);
        chk("held_conv", 32'(state_dbg), 32'(CONV));
        value_mag = 14'd42;
        @(negedge clk);
        chk("held_show", 32'(state_dbg), 32'(SHOW));
        chk("held_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        chk("held_conv2", 32'(state_dbg), 32'(CONV));
        chk("held_ready2", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        push_window(42, 1'b0);
        check_window("held42");

        load_valid = 1'b1;
        value_mag  = 14'd999;
        value_neg  = 1'b0;
        @(negedge clk);
        chk("mid_conv", 32'(state_dbg), 32'(CONV));
        load_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        exp_off = 0;
        chk("mid_rst_state", 32'(state_dbg), 32'(EMPTY));
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_digit", 32'(digit_code), 32'hF);
        chk("mid_rst_offset", 32'(offset), 32'd0);
        chk("mid_rst_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_blank();
        check_window("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
